// File: rtl/mem_arb_pkg.sv
// Shared definitions for the RAM bus arbiter: width defaults, FSM encoding
// and lock counter sizing.
package mem_arb_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 8;
  localparam int LOCK_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Counter must be able to hold the value LOCK_MAX itself.
  function automatic int lock_cnt_w(input int lock_max);
    return $clog2(lock_max + 1);
  endfunction

  localparam int LOCK_CNT_W = lock_cnt_w(LOCK_MAX_DEF);

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational winner selection: optional fixed priority for port 0, otherwise
// first candidate found scanning upward from ptr with wrap-around.
module rr_picker #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  cand,
  input  logic [PTR_W-1:0] ptr,
  input  logic             prio0_en,
  output logic [NREQ-1:0]  pick,
  output logic             found
);

  localparam int IW = PTR_W + 1;

  logic [IW-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    if (prio0_en && cand[0]) begin
      pick[0] = 1'b1;
      found   = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = {1'b0, ptr} + IW'(k);
        if (idx >= IW'(NREQ)) begin
          idx = idx - IW'(NREQ);
        end
        if (!found && cand[idx[PTR_W-1:0]]) begin
          pick[idx[PTR_W-1:0]] = 1'b1;
          found                = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates NREQ bus masters onto one synchronous RAM. State advances on the
// falling clock edge to line up with the CPU bus; read data returns one edge after grant.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PRIO0    = 1,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ-1:0]          lock,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_dout,
  output logic                     mem_write,
  output logic                     mem_read,
  input  logic [DATA_W-1:0]        mem_din,
  output logic                     busy
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int LCW   = lock_cnt_w(LOCK_MAX);

  arb_state_e        state_reg, state_next;
  logic [PTR_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0]  owner_reg, owner_next;
  logic [LCW-1:0]    lock_cnt_reg, lock_cnt_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [NREQ-1:0]   rvalid_reg, rvalid_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_dout_reg, mem_dout_next;
  logic              mem_write_reg, mem_write_next;
  logic              mem_read_reg, mem_read_next;

  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];
  logic [NREQ-1:0]   cand, pick;
  logic              found, hold_lock, grant_any;
  logic [PTR_W-1:0]  pick_idx, win;

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
  end

  // The port granted at the previous edge sits out this round.
  assign cand = req & ~gnt_reg;

  rr_picker #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .cand     (cand),
    .ptr      (rr_ptr_reg),
    .prio0_en (PRIO0 != 0),
    .pick     (pick),
    .found    (found)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        pick_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    owner_next     = owner_reg;
    lock_cnt_next  = lock_cnt_reg;
    gnt_next       = '0;
    mem_addr_next  = mem_addr_reg;
    mem_dout_next  = mem_dout_reg;
    mem_write_next = 1'b0;
    mem_read_next  = 1'b0;
    rvalid_next    = mem_read_reg ? gnt_reg : '0;
    rdata_next     = mem_read_reg ? mem_din : rdata_reg;
    win            = pick_idx;
    grant_any      = 1'b0;
    hold_lock      = (state_reg == LOCKED) && req[owner_reg] && lock[owner_reg] &&
                     (lock_cnt_reg < LCW'(LOCK_MAX));

    if (hold_lock) begin
      win           = owner_reg;
      grant_any     = 1'b1;
      lock_cnt_next = lock_cnt_reg + LCW'(1);
      state_next    = LOCKED;
    end else if (found) begin
      win           = pick_idx;
      grant_any     = 1'b1;
      lock_cnt_next = lock[pick_idx] ? LCW'(1) : '0;
      state_next    = lock[pick_idx] ? LOCKED : GRANT;
    end else begin
      lock_cnt_next = '0;
      state_next    = IDLE;
    end

    if (grant_any) begin
      gnt_next[win]  = 1'b1;
      mem_addr_next  = addr_arr[win];
      mem_dout_next  = wdata_arr[win];
      mem_write_next = we[win];
      mem_read_next  = ~we[win];
      owner_next     = win;
      rr_ptr_next    = (win == PTR_W'(NREQ - 1)) ? '0 : win + PTR_W'(1);
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      lock_cnt_reg  <= '0;
      gnt_reg       <= '0;
      rvalid_reg    <= '0;
      rdata_reg     <= '0;
      mem_addr_reg  <= '0;
      mem_dout_reg  <= '0;
      mem_write_reg <= 1'b0;
      mem_read_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      owner_reg     <= owner_next;
      lock_cnt_reg  <= lock_cnt_next;
      gnt_reg       <= gnt_next;
      rvalid_reg    <= rvalid_next;
      rdata_reg     <= rdata_next;
      mem_addr_reg  <= mem_addr_next;
      mem_dout_reg  <= mem_dout_next;
      mem_write_reg <= mem_write_next;
      mem_read_reg  <= mem_read_next;
    end
  end

  assign gnt       = gnt_reg;
  assign rvalid    = rvalid_reg;
  assign rdata     = rdata_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_dout  = mem_dout_reg;
  assign mem_write = mem_write_reg;
  assign mem_read  = mem_read_reg;
  assign busy      = (state_reg != IDLE) | mem_read_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: per-port master queues, a RAM model and
// an expected-grant queue checked mid-cycle (posedge) against the falling-edge DUT.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req, we, lock, gnt, rvalid;
  logic [15:0] addr, wdata;
  logic [7:0]  rdata, mem_addr, mem_dout, mem_din;
  logic        mem_write, mem_read, busy;

  logic [2:0]  req3, we3, lock3, gnt3, rvalid3;
  logic [23:0] addr3, wdata3;
  logic [7:0]  rdata3, mem_addr3, mem_dout3, mem_din3;
  logic        mem_write3, mem_read3, busy3;

  mem_bus_arbiter #(.NREQ(2), .ADDR_W(8), .DATA_W(8), .PRIO0(1), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_write(mem_write), .mem_read(mem_read), .mem_din(mem_din), .busy(busy)
  );

  mem_bus_arbiter #(.NREQ(3), .ADDR_W(8), .DATA_W(8), .PRIO0(0), .LOCK_MAX(4)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .we(we3), .lock(lock3), .addr(addr3), .wdata(wdata3),
    .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .mem_addr(mem_addr3), .mem_dout(mem_dout3),
    .mem_write(mem_write3), .mem_read(mem_read3), .mem_din(mem_din3), .busy(busy3)
  );

  function automatic logic [7:0] pat(input logic [7:0] a);
    return a ^ 8'h5C;
  endfunction

  function automatic logic [31:0] oh(input int p);
    return 32'd1 << p;
  endfunction

  // RAM model: preloaded during reset, responds mid-cycle so data is ready at the next falling edge.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= pat(8'(i));
      ram[8'h3C] <= 8'hA5;
    end else if (mem_write) begin
      ram[mem_addr] <= mem_dout;
    end
    if (mem_read) mem_din <= ram[mem_addr];
    mem_din3 <= pat(mem_addr3);
  end

  typedef struct {
    int         port;
    logic       wr;
    logic       lk;
    logic [7:0] a;
    logic [7:0] d;
    int         gap;
  } acc_t;

  acc_t exp_q[$];
  acc_t p0_q[$];
  acc_t p1_q[$];
  acc_t idle_c;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_gnt_cyc = 0;
  logic        rv_due = 1'b0;
  logic [31:0] rv_oh = '0;
  logic [7:0]  rv_data = '0;
  logic [1:0]  gnt_seen = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cmd(input int p, input logic wr, input logic lk, input logic [7:0] a,
                     input logic [7:0] d);
    acc_t c;
    c.port = p; c.wr = wr; c.lk = lk; c.a = a; c.d = d; c.gap = 0;
    if (p == 0) p0_q.push_back(c);
    else p1_q.push_back(c);
  endtask

  task automatic expect_acc(input int p, input logic wr, input logic [7:0] a,
                            input logic [7:0] d, input int gap);
    acc_t e;
    e.port = p; e.wr = wr; e.lk = 1'b0; e.a = a; e.d = d; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    acc_t e;
    check_eq("strobe_excl", 32'(mem_read & mem_write), 32'd0);
    if (rv_due) begin
      check_eq("rvalid", 32'(rvalid), rv_oh);
      check_eq("rdata", 32'(rdata), 32'(rv_data));
      $display("txn cyc=%0d read-return rvalid=%b rdata=%02h", cyc, rvalid, rdata);
      rv_due = 1'b0;
    end else begin
      check_eq("rvalid_idle", 32'(rvalid), 32'd0);
    end
    gnt_seen = gnt;
    if (gnt != 2'b00) begin
      if (exp_q.size() == 0) begin
        check_eq("gnt_extra", 32'(gnt), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("gnt", 32'(gnt), oh(e.port));
        check_eq("mem_addr", 32'(mem_addr), 32'(e.a));
        check_eq("mem_write", 32'(mem_write), 32'(e.wr));
        check_eq("mem_read", 32'(mem_read), 32'(!e.wr));
        if (e.wr) begin
          check_eq("mem_dout", 32'(mem_dout), 32'(e.d));
        end else begin
          rv_due  = 1'b1;
          rv_oh   = oh(e.port);
          rv_data = e.d;
        end
        if (e.gap != 0) check_eq("gap", 32'(cyc - last_gnt_cyc), 32'(e.gap));
        $display("txn cyc=%0d grant port=%0d %s addr=%02h data=%02h", cyc, e.port,
                 e.wr ? "WR" : "RD", mem_addr, e.d);
      end
      last_gnt_cyc = cyc;
    end
  endtask

  task automatic present(input int p, input logic v, input acc_t c);
    req[p]          = v;
    we[p]           = v & c.wr;
    lock[p]         = v & c.lk;
    addr[p*8 +: 8]  = c.a;
    wdata[p*8 +: 8] = c.d;
  endtask

  task automatic drive();
    if (gnt_seen[0] && p0_q.size() > 0) p0_q.delete(0);
    if (gnt_seen[1] && p1_q.size() > 0) p1_q.delete(0);
    if (p0_q.size() > 0) present(0, 1'b1, p0_q[0]);
    else present(0, 1'b0, idle_c);
    if (p1_q.size() > 0) present(1, 1'b1, p1_q[0]);
    else present(1, 1'b0, idle_c);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    monitor();
    drive();
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || p0_q.size() != 0 || p1_q.size() != 0 || rv_due) && n < budget) begin
      step();
      n++;
    end
    check_eq("drain", 32'(exp_q.size() + p0_q.size() + p1_q.size()), 32'd0);
  endtask

  initial begin
    idle_c = '{port: 0, wr: 1'b0, lk: 1'b0, a: 8'h00, d: 8'h00, gap: 0};
    rst = 1'b0; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    req3 = '0; we3 = '0; lock3 = '0; addr3 = {8'h62, 8'h61, 8'h60}; wdata3 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_rdata", 32'(rdata), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_dout", 32'(mem_dout), 32'd0);
    check_eq("rst_strobes", 32'({mem_write, mem_read}), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_gnt3", 32'({gnt3, mem_dout3}), 32'd0);
    rst = 1'b1;

    // Reset in the middle of a read: the read is dropped
    @(posedge clk);
    req = 2'b10; addr[15:8] = 8'h20;
    @(posedge clk);
    check_eq("midrd_gnt", 32'(gnt), 32'b10);
    check_eq("midrd_read", 32'({mem_read, mem_addr}), 32'h120);
    req = 2'b00;
    #2 rst = 1'b0;
    #1;
    check_eq("midrd_rst_out", 32'({gnt, rvalid, mem_read, mem_write, busy}), 32'd0);
    check_eq("midrd_rst_addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      check_eq("midrd_no_rvalid", 32'({rvalid, rdata}), 32'd0);
    end

    // Single read on port 1, then a second unlocked read that must skip one edge
    cmd(1, 1'b0, 1'b0, 8'h3C, 8'h00);
    cmd(1, 1'b0, 1'b0, 8'h3D, 8'h00);
    expect_acc(1, 1'b0, 8'h3C, 8'hA5, 0);
    expect_acc(1, 1'b0, 8'h3D, pat(8'h3D), 2);
    run(40);

    // Fixed priority with both ports requesting every cycle: 0,1,0,1,...
    for (int i = 0; i < 4; i++) begin
      cmd(0, 1'b0, 1'b0, 8'(8'h40 + i), 8'h00);
      cmd(1, 1'b0, 1'b0, 8'(8'h50 + i), 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      expect_acc(0, 1'b0, 8'(8'h40 + i), pat(8'(8'h40 + i)), (i == 0) ? 0 : 1);
      expect_acc(1, 1'b0, 8'(8'h50 + i), pat(8'(8'h50 + i)), 1);
    end
    run(60);

    // Pure round-robin, three ports all requesting: 0,1,2,0,1,2
    req3 = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      check_eq("rr3_gnt", 32'(gnt3), oh(k % 3));
      check_eq("rr3_strobes", 32'({mem_write3, mem_read3}), 32'b01);
      if (k > 0) begin
        check_eq("rr3_rvalid", 32'(rvalid3), oh((k - 1) % 3));
        check_eq("rr3_rdata", 32'(rdata3), 32'(pat(8'(96 + (k - 1) % 3))));
      end
    end
    req3 = 3'b000;
    @(posedge clk);
    check_eq("rr3_last_rvalid", 32'({gnt3, rvalid3}), 32'b000100);

    // Pipelining: port 1 write is granted on the same edge that returns port 0 read data
    cmd(0, 1'b0, 1'b0, 8'h10, 8'h00);
    cmd(1, 1'b1, 1'b0, 8'h11, 8'h5A);
    expect_acc(0, 1'b0, 8'h10, pat(8'h10), 0);
    expect_acc(1, 1'b1, 8'h11, 8'h5A, 1);
    run(40);
    step();
    check_eq("ram_11", 32'(ram[8'h11]), 32'h5A);

    // Lock: four locked grants to port 1, forced release to port 0, then port 1 resumes
    for (int i = 0; i < 6; i++) cmd(1, 1'b1, 1'b1, 8'(8'h80 + i), 8'(8'hC0 + i));
    for (int i = 0; i < 4; i++) expect_acc(1, 1'b1, 8'(8'h80 + i), 8'(8'hC0 + i), (i == 0) ? 0 : 1);
    expect_acc(0, 1'b0, 8'h90, pat(8'h90), 1);
    expect_acc(1, 1'b1, 8'h84, 8'hC4, 1);
    expect_acc(1, 1'b1, 8'h85, 8'hC5, 1);
    step();
    cmd(0, 1'b0, 1'b0, 8'h90, 8'h00);
    run(60);
    step();
    for (int i = 0; i < 6; i++) check_eq("ram_lock", 32'(ram[8'(8'h80 + i)]), 32'(8'hC0 + i));

    // Idle: no requests, everything quiet
    repeat (10) step();
    check_eq("idle_gnt", 32'({gnt, gnt3}), 32'd0);
    check_eq("idle_strobes", 32'({mem_write, mem_read, mem_write3, mem_read3}), 32'd0);
    check_eq("idle_busy", 32'({busy, busy3}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
